// File: rtl/memctl_pkg.sv
// Shared definitions for the memory access controller.
//   state_e : controller FSM states
//   WORD_W / ADDR_W / DEPTH : default data width, address width, RAM depth
package memctl_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;
endpackage

// File: rtl/mem_access_ctrl_sync_ram.sv
// sync_ram: single-port synchronous RAM, write-enable plus registered read.
//   clk  : clock
//   we   : write enable; din stored at mem[addr] on the rising edge
//   addr : word index
//   din  : write data
//   dout : registered read of mem[addr] (old data on a same-cycle write)
module sync_ram #(
  parameter int W     = 32,
  parameter int AW    = 9,
  parameter int DEPTH = 512
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one access to an internal synchronous RAM with
// WAIT_STATES wait cycles, using a four-phase read/write -> done handshake.
//   clk, clr     : clock, synchronous active-high reset
//   read, write  : level requests, held until done (both high = read)
//   addr, wdata  : sampled once in IDLE when a request is seen
//   Mdatain      : registered read data, held until the next completed read
//   busy         : state != IDLE
//   done         : access complete (DONE state)
//   addr_err     : only with MEMCTL_BOUNDS_CHECK_EN; latched addr >= DEPTH,
//                  shown during DONE. Without the macro addresses wrap
//                  onto the low index bits.
module mem_access_ctrl #(
  parameter int wordSize    = memctl_pkg::WORD_W,
  parameter int ADDR_W      = memctl_pkg::ADDR_W,
  parameter int DEPTH       = memctl_pkg::DEPTH,
  parameter int WAIT_STATES = 2
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                read,
  input  logic                write,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [wordSize-1:0] wdata,
`ifdef MEMCTL_BOUNDS_CHECK_EN
  output logic                addr_err,
`endif
  output logic [wordSize-1:0] Mdatain,
  output logic                busy,
  output logic                done
);
  import memctl_pkg::*;

  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [wordSize-1:0] wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic [wordSize-1:0] mdat_q, mdat_d;
  logic                ram_we;
  logic [wordSize-1:0] ram_dout;
  logic                oob;

`ifdef MEMCTL_BOUNDS_CHECK_EN
  assign oob = ({1'b0, addr_q} >= (ADDR_W+1)'(DEPTH));
`else
  assign oob = 1'b0;
`endif

  // The RAM address comes from the latch, which is stable from the cycle
  // after the request is sampled, so ram_dout already holds the word by
  // the time the FSM reaches ACCESS.
  sync_ram #(.W(wordSize), .AW(RAM_AW), .DEPTH(DEPTH)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (addr_q[RAM_AW-1:0]),
    .din  (wdata_q),
    .dout (ram_dout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    mdat_d  = mdat_q;
    ram_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (read | write) begin
          addr_d  = addr;
          wdata_d = wdata;
          wr_d    = write & ~read;
          cnt_d   = 4'(WAIT_STATES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = ACCESS;
      end
      ACCESS: begin
        if (wr_q) ram_we = ~oob;
        else      mdat_d = oob ? '0 : ram_dout;
        state_d = DONE;
      end
      DONE: begin
        if (!(read | write)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      mdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      mdat_q  <= mdat_d;
    end
  end

`ifdef MEMCTL_BOUNDS_CHECK_EN
  logic err_q, err_d;

  // Set on the ACCESS -> DONE edge, cleared when DONE is left.
  always_comb begin
    err_d = err_q;
    if (state_q == ACCESS)                          err_d = oob;
    else if (state_q == DONE && !(read | write))    err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (clr) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign addr_err = err_q;
`endif

  assign Mdatain = mdat_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl. Two instances share the stimulus:
// u_a uses the defaults (WAIT_STATES=2, DEPTH=512), u_b uses WAIT_STATES=0
// and DEPTH=256. 'sel' routes the request lines and output view to one.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        rd = 1'b0, wr = 1'b0, sel = 1'b0;
  logic [8:0]  addr = '0;
  logic [31:0] wdata = '0;

  logic [31:0] mdat_a, mdat_b, mdat;
  logic        busy_a, busy_b, busy, done_a, done_b, done;
  logic        rd_a, wr_a, rd_b, wr_b;
`ifdef MEMCTL_BOUNDS_CHECK_EN
  logic        err_a, err_b, aerr;
`endif

  int errs = 0;
  int checks = 0;

  assign rd_a = rd & ~sel;
  assign wr_a = wr & ~sel;
  assign rd_b = rd & sel;
  assign wr_b = wr & sel;
  assign mdat = sel ? mdat_b : mdat_a;
  assign busy = sel ? busy_b : busy_a;
  assign done = sel ? done_b : done_a;
`ifdef MEMCTL_BOUNDS_CHECK_EN
  assign aerr = sel ? err_b : err_a;
`endif

  always #5 clk = ~clk;

  mem_access_ctrl u_a (
    .clk(clk), .clr(clr), .read(rd_a), .write(wr_a), .addr(addr), .wdata(wdata),
`ifdef MEMCTL_BOUNDS_CHECK_EN
    .addr_err(err_a),
`endif
    .Mdatain(mdat_a), .busy(busy_a), .done(done_a)
  );

  mem_access_ctrl #(.wordSize(32), .ADDR_W(9), .DEPTH(256), .WAIT_STATES(0)) u_b (
    .clk(clk), .clr(clr), .read(rd_b), .write(wr_b), .addr(addr), .wdata(wdata),
`ifdef MEMCTL_BOUNDS_CHECK_EN
    .addr_err(err_b),
`endif
    .Mdatain(mdat_b), .busy(busy_b), .done(done_b)
  );

  // Raise a request, let it be sampled, scramble addr/wdata afterwards and
  // count edges from the sampling edge until done is seen (bounded).
  task automatic req(input logic r, input logic w, input logic [8:0] a,
                     input logic [31:0] d, output int lat);
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    addr = ~a; wdata = ~d;
    lat = 0;
    while (!done && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_req();
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rd = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (mdat_a !== 32'h0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
        $display("FAIL reset_a cyc%0d: mdat=%h busy=%b done=%b want 0/0/0", i, mdat_a, busy_a, done_a);
        errs++;
      end
      checks++;
      if (mdat_b !== 32'h0 || busy_b !== 1'b0 || done_b !== 1'b0) begin
        $display("FAIL reset_b cyc%0d: mdat=%h busy=%b done=%b want 0/0/0", i, mdat_b, busy_b, done_b);
        errs++;
      end
    end
    @(negedge clk);
    clr = 1'b0; rd = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      $display("FAIL reset_no_start: busy_a=%b busy_b=%b want 0/0", busy_a, busy_b);
      errs++;
    end
  endtask

  task automatic test_write_read();
    int lat;
    sel = 1'b0;
    req(1'b0, 1'b1, 9'h012, 32'hDEADBEEF, lat);
    checks++;
    if (lat !== 4) begin $display("FAIL wr_latency: got %0d want 4", lat); errs++; end
    checks++;
    if (busy !== 1'b1 || mdat !== 32'h0) begin
      $display("FAIL wr_done_state: busy=%b mdat=%h want 1/00000000", busy, mdat); errs++;
    end
    release_req();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL wr_release: busy=%b done=%b want 0/0", busy, done); errs++;
    end
    req(1'b1, 1'b0, 9'h012, 32'h0, lat);
    checks++;
    if (lat !== 4) begin $display("FAIL rd_latency: got %0d want 4", lat); errs++; end
    checks++;
    if (mdat !== 32'hDEADBEEF) begin $display("FAIL rd_data: got %h want deadbeef", mdat); errs++; end
    release_req();
  endtask

  task automatic test_zero_wait();
    int lat;
    sel = 1'b1;
    req(1'b0, 1'b1, 9'h000, 32'h00000005, lat);
    checks++;
    if (lat !== 2) begin $display("FAIL zw_wr_latency: got %0d want 2", lat); errs++; end
    release_req();
    req(1'b1, 1'b0, 9'h000, 32'h0, lat);
    checks++;
    if (lat !== 2) begin $display("FAIL zw_rd_latency: got %0d want 2", lat); errs++; end
    checks++;
    if (mdat !== 32'h5) begin $display("FAIL zw_rd_data: got %h want 00000005", mdat); errs++; end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b1 || mdat !== 32'h5) begin
        $display("FAIL zw_hold cyc%0d: done=%b mdat=%h want 1/00000005", i, done, mdat); errs++;
      end
    end
    release_req();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        $display("FAIL zw_no_retrigger cyc%0d: busy=%b done=%b want 0/0", i, busy, done); errs++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_rd_wr_both();
    int lat;
    sel = 1'b0;
    req(1'b0, 1'b1, 9'h020, 32'h11112222, lat);
    release_req();
    req(1'b1, 1'b1, 9'h020, 32'hFFFFFFFF, lat);
    checks++;
    if (mdat !== 32'h11112222) begin $display("FAIL both_rd_data: got %h want 11112222", mdat); errs++; end
    release_req();
    req(1'b1, 1'b0, 9'h020, 32'h0, lat);
    checks++;
    if (mdat !== 32'h11112222) begin $display("FAIL both_no_write: got %h want 11112222", mdat); errs++; end
    release_req();
  endtask

  task automatic test_reset_mid_write();
    int lat;
    sel = 1'b0;
    req(1'b0, 1'b1, 9'h030, 32'hAAAA0000, lat);
    release_req();
    @(negedge clk);
    wr = 1'b1; addr = 9'h030; wdata = 32'h12345678;
    @(posedge clk);          // sampled, now in WAIT
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || mdat !== 32'h0) begin
      $display("FAIL midrst_state: busy=%b done=%b mdat=%h want 0/0/0", busy, done, mdat); errs++;
    end
    @(negedge clk);
    clr = 1'b0; wr = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    req(1'b1, 1'b0, 9'h030, 32'h0, lat);
    checks++;
    if (lat !== 4 || mdat !== 32'hAAAA0000) begin
      $display("FAIL midrst_ram: lat=%0d mdat=%h want 4/aaaa0000", lat, mdat); errs++;
    end
    release_req();
  endtask

  task automatic test_out_of_range();
    int lat;
    sel = 1'b1;
    req(1'b0, 1'b1, 9'h0FF, 32'hCAFEF00D, lat);
    release_req();
`ifdef MEMCTL_BOUNDS_CHECK_EN
    req(1'b0, 1'b1, 9'h1FF, 32'h0BAD0BAD, lat);
    checks++;
    if (aerr !== 1'b1) begin $display("FAIL oob_wr_err: got %b want 1", aerr); errs++; end
    release_req();
    req(1'b1, 1'b0, 9'h1FF, 32'h0, lat);
    checks++;
    if (mdat !== 32'h0 || aerr !== 1'b1) begin
      $display("FAIL oob_rd: mdat=%h err=%b want 00000000/1", mdat, aerr); errs++;
    end
    release_req();
    checks++;
    if (aerr !== 1'b0) begin $display("FAIL oob_err_clear: got %b want 0", aerr); errs++; end
    req(1'b1, 1'b0, 9'h0FF, 32'h0, lat);
    checks++;
    if (mdat !== 32'hCAFEF00D || aerr !== 1'b0) begin
      $display("FAIL oob_wr_suppressed: mdat=%h err=%b want cafef00d/0", mdat, aerr); errs++;
    end
    release_req();
`else
    req(1'b1, 1'b0, 9'h1FF, 32'h0, lat);
    checks++;
    if (lat !== 2 || mdat !== 32'hCAFEF00D) begin
      $display("FAIL oob_wrap: lat=%0d mdat=%h want 2/cafef00d", lat, mdat); errs++;
    end
    release_req();
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_wait();
    test_rd_wr_both();
    test_reset_mid_write();
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
